// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT coefficient output path.
package dct_pkg;

    localparam int DCT_K      = 23;
    localparam int DCT_FRAC   = 12;
    localparam int DCT_ACC_W  = 28;
    localparam int DCT_COEF_W = 16;
    localparam int DCT_NCOEF  = 8;
    localparam int DCT_IDX_W  = 3;

    localparam logic signed [DCT_COEF_W-1:0] DCT_SAT_MAX = 16'sh7fff;
    localparam logic signed [DCT_COEF_W-1:0] DCT_SAT_MIN = 16'sh8000;

    typedef struct packed {
        logic signed [DCT_COEF_W-1:0] coef;
        logic        [DCT_IDX_W-1:0]  idx;
    } dct_entry_t;

endpackage

// File: rtl/dct_sync_fifo.sv
// Small synchronous FIFO; head entry is driven straight from the storage registers.
module dct_sync_fifo #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dct_coef_out.sv
// DCT output stage: detects completed K-term sums, rounds/saturates the
// accumulator and queues {coef, idx} for a valid/ready consumer.
module dct_coef_out
    import dct_pkg::*;
#(
    parameter int K     = DCT_K,
    parameter int FRAC  = DCT_FRAC,
    parameter int NCOEF = DCT_NCOEF,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         new1,
    input  logic signed [DCT_ACC_W-1:0]  acc,
    output logic signed [DCT_COEF_W-1:0] coef,
    output logic        [DCT_IDX_W-1:0]  coef_idx,
    output logic                         coef_valid,
    input  logic                         coef_ready,
    output logic                         overrun,
    output logic                         seq_err
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int RW    = DCT_ACC_W + 1 - FRAC;
    localparam logic [DCT_ACC_W:0] HALF = (DCT_ACC_W+1)'(1) << (FRAC - 1);

    logic [CNT_W-1:0]     cnt;
    logic                 done;
    logic [DCT_IDX_W-1:0] idx_ctr;
    dct_entry_t           push_entry;
    dct_entry_t           head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Round half up and drop the fraction bits; one guard bit keeps the add exact.
    function automatic logic signed [RW-1:0] round_frac(input logic signed [DCT_ACC_W-1:0] a);
        logic [DCT_ACC_W:0] s;
        s = {a[DCT_ACC_W-1], a} + HALF;
        return s[DCT_ACC_W:FRAC];
    endfunction

    function automatic logic signed [DCT_COEF_W-1:0] sat_coef(input logic signed [RW-1:0] r);
        if (&r[RW-1:DCT_COEF_W-1] || ~|r[RW-1:DCT_COEF_W-1])
            return r[DCT_COEF_W-1:0];
        else if (r[RW-1])
            return DCT_SAT_MIN;
        else
            return DCT_SAT_MAX;
    endfunction

    // Stage 0: term counting, mirrors the accumulator strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            done    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                if (new1) begin
                    cnt  <= CNT_W'(1);
                    done <= (K == 1);
                end else if (cnt != '0 && cnt < CNT_W'(K)) begin
                    cnt  <= cnt + 1'b1;
                    done <= (cnt == CNT_W'(K - 1));
                end else begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

    // Stage 1: acc holds the final sum while done is high; round, saturate and push.
    always_comb begin
        push_entry      = '0;
        push_entry.coef = sat_coef(round_frac(acc));
        push_entry.idx  = idx_ctr;
    end

    assign pop = coef_valid && coef_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_ctr <= '0;
            overrun <= 1'b0;
        end else if (done) begin
            idx_ctr <= (idx_ctr == DCT_IDX_W'(NCOEF - 1)) ? '0 : idx_ctr + 1'b1;
            if (fifo_full && !pop) overrun <= 1'b1;
        end
    end

    dct_sync_fifo #(
        .DATA_W ($bits(dct_entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (done),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stage 2: FIFO head is the output.
    assign coef_valid = !fifo_empty;
    assign coef       = head.coef;
    assign coef_idx   = head.idx;

endmodule
